// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv
// Falling-edge WIDTH x DEPTH register pipeline with per-stage valid,
// shift enable, full-chain scan and occupancy count.
module gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe #(
  parameter int unsigned             WIDTH     = 8,
  parameter int unsigned             DEPTH     = 4,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
  input  logic                               CLKN,
  input  logic                               RN,
  input  logic                               E,
  input  logic [WIDTH-1:0]                   D,
  input  logic                               VI,
  input  logic                               SE,
  input  logic                               SI,
  output logic [WIDTH-1:0]                   Q,
  output logic                               VO,
  output logic                               SO,
  output logic [$clog2(DEPTH+1)-1:0]         FILL
);

  localparam int unsigned N  = WIDTH * DEPTH;
  localparam int unsigned FW = $clog2(DEPTH + 1);

  // Stage i occupies data bits [i*WIDTH +: WIDTH]; bit 0 of stage 0 is the scan head.
  logic [N-1:0]     data_q, data_d;
  logic [DEPTH-1:0] vld_q,  vld_d;
  logic [FW-1:0]    fill_q, fill_d;

  logic [N-1:0]     data_scan, data_shift, data_run;
  logic [DEPTH-1:0] vld_shift, vld_run;
  logic [FW-1:0]    fill_shift, fill_run;
  logic             rst_x;

  always_comb begin
    data_scan     = data_q << 1;
    data_scan[0]  = SI;

    data_shift              = data_q << WIDTH;
    data_shift[WIDTH-1:0]   = D;

    vld_shift     = vld_q << 1;
    vld_shift[0]  = VI;

    fill_shift    = fill_q + FW'(VI) - FW'(vld_q[DEPTH-1]);

    // Ternaries rather than if/else so an X on SE or E merges into X
    // instead of silently selecting the hold path in simulation.
    data_run = SE ? data_scan : (E ? data_shift : data_q);
    vld_run  = SE ? vld_q     : (E ? vld_shift  : vld_q);
    fill_run = SE ? fill_q    : (E ? fill_shift : fill_q);

    // Zero for a known RN, all-X for an unknown one: poisons every next-state bit.
    rst_x  = RN ^ RN;

    data_d = (RN ? data_run : {DEPTH{RESET_VAL}}) ^ {N{rst_x}};
    vld_d  = (RN ? vld_run  : '0)                 ^ {DEPTH{rst_x}};
    fill_d = (RN ? fill_run : '0)                 ^ {FW{rst_x}};
  end

  always_ff @(negedge CLKN) begin
    data_q <= data_d;
    vld_q  <= vld_d;
    fill_q <= fill_d;
  end

  assign Q    = data_q[N-1 -: WIDTH];
  assign VO   = vld_q[DEPTH-1];
  assign SO   = data_q[N-1];
  assign FILL = fill_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv
// Directed self-checking bench for the falling-edge register pipeline.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe;

  logic       CLKN = 1'b1;
  logic       RN   = 1'b0;
  logic       E    = 1'b0;
  logic [7:0] D    = 8'h00;
  logic       VI   = 1'b0;
  logic       SE   = 1'b0;
  logic       SI   = 1'b0;
  logic [7:0] Q;
  logic       VO;
  logic       SO;
  logic [2:0] FILL;

  int n_cmp = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe #(
    .WIDTH    (8),
    .DEPTH    (4),
    .RESET_VAL(8'hA5)
  ) dut (
    .CLKN(CLKN),
    .RN  (RN),
    .E   (E),
    .D   (D),
    .VI  (VI),
    .SE  (SE),
    .SI  (SI),
    .Q   (Q),
    .VO  (VO),
    .SO  (SO),
    .FILL(FILL)
  );

  always #5 CLKN = ~CLKN;

  task automatic fall();
    @(negedge CLKN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    RN = 1'b0; E = 1'b1; SE = 1'b0; D = 8'h3C; VI = 1'b1;
    fall();
    chk("rst_q",    32'(Q),    32'hA5);
    chk("rst_vo",   32'(VO),   32'h0);
    chk("rst_so",   32'(SO),   32'h1);
    chk("rst_fill", 32'(FILL), 32'h0);

    // Latency / fill
    RN = 1'b1; E = 1'b1; VI = 1'b1;
    D = 8'h01; fall();
    chk("lat1_fill", 32'(FILL), 32'h1);
    D = 8'h02; fall();
    D = 8'h03; fall();
    chk("lat3_vo",   32'(VO),   32'h0);
    chk("lat3_fill", 32'(FILL), 32'h3);
    D = 8'h04; fall();
    chk("lat4_q",    32'(Q),    32'h01);
    chk("lat4_vo",   32'(VO),   32'h1);
    chk("lat4_fill", 32'(FILL), 32'h4);

    // Rising edge alone with RN low must not disturb state
    RN = 1'b0;
    @(posedge CLKN); #1;
    chk("rise_q",    32'(Q),    32'h01);
    chk("rise_fill", 32'(FILL), 32'h4);
    RN = 1'b1;

    VI = 1'b0; D = 8'hFF; fall();
    chk("lat5_q",    32'(Q),    32'h02);
    chk("lat5_fill", 32'(FILL), 32'h3);
    fall();
    chk("lat6_q",    32'(Q),    32'h03);
    chk("lat6_fill", 32'(FILL), 32'h2);

    // Refill, then hold
    VI = 1'b1;
    D = 8'h11; fall();
    D = 8'h22; fall();
    D = 8'h33; fall();
    D = 8'h44; fall();
    chk("refill_q",    32'(Q),    32'h11);
    chk("refill_fill", 32'(FILL), 32'h4);
    E = 1'b0;
    for (int i = 0; i < 10; i++) begin
      D  = (i % 2 == 0) ? 8'h5A : 8'hC3;
      VI = (i % 2 == 0) ? 1'b0 : 1'b1;
      fall();
      chk("hold_q",    32'(Q),    32'h11);
      chk("hold_vo",   32'(VO),   32'h1);
      chk("hold_fill", 32'(FILL), 32'h4);
    end

    // Scan: E asserted but ignored; flush chain with zeros first
    SE = 1'b1; E = 1'b1; VI = 1'b0; D = 8'hFF; SI = 1'b0;
    for (int i = 0; i < 32; i++) fall();
    chk("scan_flush_q",  32'(Q),    32'h00);
    chk("scan_flush_so", 32'(SO),   32'h0);
    chk("scan_fill",     32'(FILL), 32'h4);
    chk("scan_vo",       32'(VO),   32'h1);
    SI = 1'b1; fall();
    SI = 1'b0;
    for (int i = 2; i <= 31; i++) begin
      fall();
      chk("scan_so_early", 32'(SO), 32'h0);
    end
    fall();
    chk("scan_so_32",   32'(SO),   32'h1);
    chk("scan_q_32",    32'(Q),    32'h80);
    chk("scan_fill_32", 32'(FILL), 32'h4);
    fall();
    chk("scan_so_33",   32'(SO),   32'h0);

    // Reset mid-operation with E and SE both high
    RN = 1'b0; E = 1'b1; SE = 1'b1; SI = 1'b1;
    fall();
    chk("midrst_q",    32'(Q),    32'hA5);
    chk("midrst_vo",   32'(VO),   32'h0);
    chk("midrst_fill", 32'(FILL), 32'h0);

    // Bubbles
    RN = 1'b1; SE = 1'b0; E = 1'b1; SI = 1'b0;
    VI = 1'b1; D = 8'h10; fall();
    chk("bub1_fill", 32'(FILL), 32'h1);
    VI = 1'b0; D = 8'h20; fall();
    chk("bub2_fill", 32'(FILL), 32'h1);
    VI = 1'b1; D = 8'h30; fall();
    chk("bub3_fill", 32'(FILL), 32'h2);
    VI = 1'b0; D = 8'h40; fall();
    chk("bub4_fill", 32'(FILL), 32'h2);
    chk("bub4_vo",   32'(VO),   32'h1);
    chk("bub4_q",    32'(Q),    32'h10);
    D = 8'h00;
    fall();
    chk("bub5_vo",   32'(VO),   32'h0);
    chk("bub5_q",    32'(Q),    32'h20);
    chk("bub5_fill", 32'(FILL), 32'h1);
    fall();
    chk("bub6_vo",   32'(VO),   32'h1);
    chk("bub6_q",    32'(Q),    32'h30);
    chk("bub6_fill", 32'(FILL), 32'h1);
    fall();
    chk("bub7_vo",   32'(VO),   32'h0);
    chk("bub7_fill", 32'(FILL), 32'h0);
    fall();
    chk("bub8_vo",   32'(VO),   32'h0);
    chk("bub8_fill", 32'(FILL), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
